// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline registers / memory port and the hazard controller.
// The pipeline side uses the master modport; hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) ();
  logic                  memread_id_ex;
  logic [REG_ADDR_W-1:0] dst_reg_id_ex;
  logic [REG_ADDR_W-1:0] src_reg1_if_id;
  logic [REG_ADDR_W-1:0] src_reg2_if_id;
  logic                  src1_used;
  logic                  src2_used;
  logic                  memread_ex_mem;
  logic                  memwrite_ex_mem;
  logic                  mem_ready;
  logic                  branch_taken_ex;
  logic                  int_req;
  logic                  hazard;
  logic                  stall_if_id;
  logic                  bubble_id_ex;
  logic                  stall_mem;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  int_ack;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output memread_id_ex, dst_reg_id_ex, src_reg1_if_id, src_reg2_if_id, src1_used, src2_used,
    output memread_ex_mem, memwrite_ex_mem, mem_ready, branch_taken_ex, int_req,
    input  hazard, stall_if_id, bubble_id_ex, stall_mem, flush_if_id, flush_id_ex, int_ack,
    input  stall_count
  );

  modport slave (
    input  memread_id_ex, dst_reg_id_ex, src_reg1_if_id, src_reg2_if_id, src1_used, src2_used,
    input  memread_ex_mem, memwrite_ex_mem, mem_ready, branch_taken_ex, int_req,
    output hazard, stall_if_id, bubble_id_ex, stall_mem, flush_if_id, flush_id_ex, int_ack,
    output stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use hazard detection, memory-access pipeline stall FSM, branch/interrupt flush
// sequencing and a saturating stalled-cycle counter for the in-order core.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned MEM_STALL_CYCLES = 1,
  parameter bit          USE_MEM_READY    = 1'b0,
  parameter bit          ZERO_REG_EXEMPT  = 1'b1,
  parameter int unsigned CNT_W            = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned CntW = (MEM_STALL_CYCLES < 1) ? 1 : $clog2(MEM_STALL_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StRelease} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_stall_mem, w_stall_mem_d;
  logic             r_int_pending;
  logic [CNT_W-1:0] r_stall_count;

  logic w_memop, w_dst_zero, w_src_hit, w_hazard, w_ready_ok, w_int_ack, w_branch;

  assign w_branch   = hz.branch_taken_ex;
  assign w_memop    = hz.memread_ex_mem | hz.memwrite_ex_mem;
  assign w_dst_zero = ZERO_REG_EXEMPT && (hz.dst_reg_id_ex == '0);
  assign w_src_hit  = ((hz.dst_reg_id_ex == hz.src_reg1_if_id) && hz.src1_used) ||
                      ((hz.dst_reg_id_ex == hz.src_reg2_if_id) && hz.src2_used);
  assign w_hazard   = hz.memread_id_ex & ~w_dst_zero & w_src_hit;
  assign w_ready_ok = hz.mem_ready | ~USE_MEM_READY;

  // Interrupts only go in on a clean IDLE cycle so the flush never races a stall or branch.
  assign w_int_ack  = r_int_pending & (r_state == StIdle) & ~w_memop & ~w_branch &
                      ~w_hazard & ~r_stall_mem;

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_stall_mem_d = r_stall_mem;
    unique case (r_state)
      StIdle: begin
        if (w_memop) begin
          w_state_d     = StWait;
          w_cnt_d       = CntW'(MEM_STALL_CYCLES - 1);
          w_stall_mem_d = 1'b1;
        end
      end
      StWait: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CntW'(1);
        end else if (w_ready_ok) begin
          w_state_d     = StRelease;
          w_stall_mem_d = 1'b0;
        end
      end
      StRelease: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d     = StIdle;
        w_stall_mem_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_stall_mem   <= 1'b0;
      r_int_pending <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_stall_mem   <= w_stall_mem_d;
      r_int_pending <= w_int_ack ? 1'b0 : (r_int_pending | hz.int_req);
      if (r_stall_mem && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign hz.hazard       = w_hazard;
  assign hz.stall_mem    = r_stall_mem;
  assign hz.stall_if_id  = r_stall_mem | (w_hazard & ~w_branch & ~w_int_ack);
  assign hz.bubble_id_ex = ~r_stall_mem & w_hazard & ~w_branch & ~w_int_ack;
  assign hz.flush_if_id  = ~r_stall_mem & (w_branch | w_int_ack);
  assign hz.flush_id_ex  = ~r_stall_mem & (w_branch | w_int_ack);
  assign hz.int_ack      = w_int_ack;
  assign hz.stall_count  = r_stall_count;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard and stall controller for the in-order core, between the IF/ID, ID/EX and EX/MEM pipeline registers and the data-memory port. It detects load-use hazards, with optional x0 exemption and per-source valid qualifiers. It holds the whole pipeline for a configurable number of cycles on every EX/MEM memory access, optionally extended by a memory-ready handshake. It also sequences branch flushes, arbitrates pending interrupts against stalls, and counts stalled cycles.

## Interface
- REG_ADDR_W, 5, register-index width
- MEM_STALL_CYCLES, 1, minimum full-pipeline stall cycles per memory op (≥1)
- USE_MEM_READY, 0, 1: WAIT also requires mem_ready
- ZERO_REG_EXEMPT, 1, 1: destination index 0 never creates a load-use hazard
- CNT_W, 16, stall counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- memread_id_ex  in  1  load in ID/EX
- dst_reg_id_ex  in  REG_ADDR_W  ID/EX destination
- src_reg1_if_id, src_reg2_if_id  in  REG_ADDR_W  IF/ID sources
- src1_used, src2_used  in  1  source actually read by the IF/ID instruction
- memread_ex_mem, memwrite_ex_mem  in  1  memory op in EX/MEM
- mem_ready  in  1  memory completion; ignored when USE_MEM_READY=0
- branch_taken_ex  in  1  taken branch, jump or rti resolved in EX
- int_req  in  1  interrupt request pulse/level
- hazard  out  1  load-use hazard (combinational)
- stall_if_id  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  insert NOP into ID/EX
- stall_mem  out  1  hold all pipeline registers (registered)
- flush_if_id, flush_id_ex  out  1  squash stage contents
- int_ack  out  1  one-cycle interrupt acceptance
- stall_count  out  CNT_W  saturating count of stall_mem-high cycles

## Operation
- hazard = memread_id_ex & ~(ZERO_REG_EXEMPT & dst==0) & ((dst==src1 & src1_used) | (dst==src2 & src2_used)).
- memop = memread_ex_mem | memwrite_ex_mem.
- FSM IDLE / WAIT / RELEASE; cnt of width clog2(MEM_STALL_CYCLES+1).
  - IDLE: memop → WAIT, cnt ← MEM_STALL_CYCLES-1, stall_mem ← 1.
  - WAIT: cnt≠0 → decrement. cnt==0 & (mem_ready | ~USE_MEM_READY) → RELEASE, stall_mem ← 0.
  - RELEASE: memop ignored; pipeline advances; → IDLE unconditionally.
- Priority, evaluated only while stall_mem=0 (while stall_mem=1 all of flush/bubble/int_ack are 0):
  1. branch_taken_ex: flush_if_id = flush_id_ex = 1; hazard-driven stall_if_id and bubble_id_ex suppressed.
  2. int_ack: flush_if_id = flush_id_ex = 1.
  3. hazard: stall_if_id = 1, bubble_id_ex = 1.
- stall_if_id = stall_mem | (hazard & ~branch_taken_ex & ~int_ack).
- int_pending set on int_req, cleared on int_ack; int_req while pending is absorbed (one ack).
- int_ack = int_pending & state==IDLE & ~memop & ~branch_taken_ex & ~hazard & ~stall_mem.
- stall_count increments each cycle stall_mem=1; saturates at 2^CNT_W-1.

## Timing
- Reset values: state IDLE, stall_mem 0, cnt 0, int_pending 0, stall_count 0. Combinational outputs follow their inputs.
- Memory op first visible in cycle t (IDLE):
  - stall_mem = 1 for cycles t+1 .. t+MEM_STALL_CYCLES, plus mem_ready wait cycles.
  - RELEASE cycle has stall_mem = 0.
  - Earliest next trigger is sampled the cycle after RELEASE.
- mem_ready is sampled only in WAIT with cnt==0; mem_ready early or held high does not shorten the minimum stall.
- Back-to-back memory ops: period MEM_STALL_CYCLES+2 cycles per op with mem_ready tied high.
- Reset mid-WAIT: next cycle IDLE, stall_mem 0, pending interrupt dropped.
- Simultaneous branch_taken_ex and hazard: flush wins, no bubble.
- Simultaneous branch_taken_ex and int_pending: flush only; int_ack deferred to the next eligible cycle.
- int_ack: one cycle, earliest the cycle after int_req is registered.

## Test plan
- Load-use: memread_id_ex=1, dst=5, src1=5, src1_used=1 → hazard=stall_if_id=bubble_id_ex=1. Same with dst=0 and ZERO_REG_EXEMPT=1 → all 0. Same with src1_used=0 → all 0.
- MEM_STALL_CYCLES=3, memread_ex_mem held high 20 cycles → stall_mem pattern 0,1,1,1,0 repeating; stall_count=12 after 20 cycles.
- USE_MEM_READY=1, MEM_STALL_CYCLES=1, mem_ready rises 4 cycles after trigger → stall_mem high exactly 4 cycles, then RELEASE.
- branch_taken_ex with hazard → flush_if_id=flush_id_ex=1, stall_if_id=0. branch_taken_ex during stall_mem → no flush until stall_mem falls.
- int_req pulse during WAIT → int_ack only in the first IDLE cycle with no memop, hazard or branch; int_ack is one cycle wide; a second int_req while pending yields one ack.
- rst_n low at the second WAIT cycle → stall_mem=0, stall_count=0 next cycle. CNT_W=4 with 20 stall cycles → stall_count=15.
